// File: rtl/decode_hazard_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_hazard_stage : RV32I/RV64I decode stage with RAW hazard stalls
// Revision: 1.0
// ---------------------------------------------------------------------------
module decode_hazard_stage #(
   parameter int          XLEN       = 32,
   parameter int          HIST_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = 32'h00400000,
   parameter int          CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr_in,
   input  logic [XLEN-1:0]  pc_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [6:0]       opcode,
   output logic [2:0]       func3,
   output logic [6:0]       func7,
   output logic [XLEN-1:0]  imm,
   output logic [XLEN-1:0]  pc_out,
   output logic             illegal,
   output logic [CNT_W-1:0] stall_count
);

   logic [4:0]        hist [HIST_DEPTH];
   logic [4:0]        hist_in;
   logic [4:0]        f_rs1, f_rs2, f_rd, eff_rd;
   logic [6:0]        f_op;
   logic              uses_rs1, uses_rs2, writes_rd, bad_op;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]   imm_dec;
   logic              hit1, hit2, hazard, adv, accept;

   assign f_op  = instr_in[6:0];
   assign f_rd  = instr_in[11:7];
   assign f_rs1 = instr_in[19:15];
   assign f_rs2 = instr_in[24:20];

   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      bad_op    = 1'b0;
      imm32     = '0;
      case (f_op)
         7'b0110011: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            writes_rd = 1'b1;
         end
         7'b0010011, 7'b0000011, 7'b1100111: begin
            uses_rs1  = 1'b1;
            writes_rd = 1'b1;
            imm32     = {{20{instr_in[31]}}, instr_in[31:20]};
         end
         7'b0100011: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm32    = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
         end
         7'b1100011: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            imm32    = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                        instr_in[30:25], instr_in[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            writes_rd = 1'b1;
            imm32     = {instr_in[31:12], 12'b0};
         end
         7'b1101111: begin
            writes_rd = 1'b1;
            imm32     = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                         instr_in[20], instr_in[30:21], 1'b0};
         end
         default: bad_op = 1'b1;
      endcase
   end

   assign imm_dec = XLEN'(imm32);
   assign eff_rd  = (writes_rd && f_rd != 5'd0) ? f_rd : 5'd0;

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
         if (hist[i] == f_rs1) hit1 = 1'b1;
         if (hist[i] == f_rs2) hit2 = 1'b1;
      end
   end

   assign hazard   = in_valid & ((uses_rs1 & (f_rs1 != 5'd0) & hit1) |
                                 (uses_rs2 & (f_rs2 != 5'd0) & hit2));
   assign adv      = ~out_valid | out_ready;
   assign accept   = in_valid & ~hazard;
   assign in_ready = adv & ~hazard & ~flush & ~reset;
   // Bubbles push a zero so an older destination ages out of the window.
   assign hist_in  = accept ? eff_rd : 5'd0;

   generate
      for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_hist
         if (g == 0) begin : g_head
            always_ff @(posedge clock) begin
               if (reset || flush) hist[g] <= 5'd0;
               else if (adv)       hist[g] <= hist_in;
            end
         end else begin : g_tail
            always_ff @(posedge clock) begin
               if (reset || flush) hist[g] <= 5'd0;
               else if (adv)       hist[g] <= hist[g-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid   <= 1'b0;
         {rs1, rs2, rd, opcode, func3, func7, illegal} <= '0;
         imm         <= '0;
         pc_out      <= XLEN'(RESET_PC);
         stall_count <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         {rs1, rs2, rd, opcode, func3, func7, illegal} <= '0;
         imm       <= '0;
         pc_out    <= '0;
      end else if (adv) begin
         if (accept) begin
            out_valid <= 1'b1;
            rs1       <= f_rs1;
            rs2       <= f_rs2;
            rd        <= f_rd;
            opcode    <= f_op;
            func3     <= instr_in[14:12];
            func7     <= instr_in[31:25];
            imm       <= imm_dec;
            illegal   <= bad_op;
            pc_out    <= pc_in;
         end else begin
            out_valid <= 1'b0;
            {rs1, rs2, rd, opcode, func3, func7, illegal} <= '0;
            imm       <= '0;
            if (hazard && stall_count != {CNT_W{1'b1}})
               stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_decode_hazard_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decode_hazard_stage : directed self-checking bench, XLEN 32 and 64 copies
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_decode_hazard_stage;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] instr_in, pc32;
   logic [63:0] pc64;

   logic        a_in_ready, a_out_valid, a_illegal;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [6:0]  a_opcode, a_func7;
   logic [2:0]  a_func3;
   logic [31:0] a_imm, a_pc_out;
   logic [15:0] a_stall;

   logic        b_in_ready, b_out_valid, b_illegal;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [6:0]  b_opcode, b_func7;
   logic [2:0]  b_func3;
   logic [63:0] b_imm, b_pc_out;
   logic [15:0] b_stall;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   decode_hazard_stage #(.XLEN(32), .HIST_DEPTH(2)) dut32 (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_ready(a_in_ready), .instr_in(instr_in), .pc_in(pc32),
      .out_valid(a_out_valid), .out_ready(out_ready), .rs1(a_rs1), .rs2(a_rs2),
      .rd(a_rd), .opcode(a_opcode), .func3(a_func3), .func7(a_func7),
      .imm(a_imm), .pc_out(a_pc_out), .illegal(a_illegal), .stall_count(a_stall)
   );

   decode_hazard_stage #(.XLEN(64), .HIST_DEPTH(2)) dut64 (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_ready(b_in_ready), .instr_in(instr_in), .pc_in(pc64),
      .out_valid(b_out_valid), .out_ready(out_ready), .rs1(b_rs1), .rs2(b_rs2),
      .rd(b_rd), .opcode(b_opcode), .func3(b_func3), .func7(b_func7),
      .imm(b_imm), .pc_out(b_pc_out), .illegal(b_illegal), .stall_count(b_stall)
   );

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  opc;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic        ill;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
      instr_in = ins;
      pc32     = pc;
      pc64     = {32'h0, pc};
      in_valid = 1'b1;
   endtask

   // Waits (bounded) until the held instruction is accepted, counting bubbles.
   task automatic wait_accept(output int bubbles, output bit ok);
      bubbles = 0;
      ok      = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         #1;
         if (a_in_ready) ok = 1'b1;
         else bubbles++;
         tick();
      end
   endtask

   int bub;
   bit ok;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h00700293, 7'h13, 5'd5,  5'd0,  5'd7,  3'd0, 7'h00, 64'h7, 1'b0};
      vecs[1] = '{32'hFE112E23, 7'h23, 5'd28, 5'd2,  5'd1,  3'd2, 7'h7F, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      vecs[2] = '{32'hFF9FF0EF, 7'h6F, 5'd1,  5'd31, 5'd25, 3'd7, 7'h7F, 64'hFFFFFFFFFFFFFFF8, 1'b0};
      vecs[3] = '{32'h0000007F, 7'h7F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 64'h0, 1'b1};
      vecs[4] = '{32'h12345537, 7'h37, 5'd10, 5'd8,  5'd3,  3'd5, 7'h09, 64'h12345000, 1'b0};
      vecs[5] = '{32'hFE2088E3, 7'h63, 5'd17, 5'd1,  5'd2,  3'd0, 7'h7F, 64'hFFFFFFFFFFFFFFF0, 1'b0};
      vecs[6] = '{32'h00528333, 7'h33, 5'd6,  5'd5,  5'd5,  3'd0, 7'h00, 64'h0, 1'b0};
      vecs[7] = '{32'hFFF1A383, 7'h03, 5'd7,  5'd3,  5'd31, 3'd2, 7'h7F, 64'hFFFFFFFFFFFFFFFF, 1'b0};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr_in = '0; pc32 = '0; pc64 = '0;
      tick(); tick();
      check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
      check("rst_pc32", {32'd0, a_pc_out}, 64'h00400000);
      check("rst_pc64", b_pc_out, 64'h00400000);
      check("rst_stall", {48'd0, a_stall}, 64'd0);
      reset = 1'b0;
      #1;
      check("rst_in_ready", {63'd0, a_in_ready}, 64'd1);

      // addi x5,x0,7 followed by dependent add x6,x5,x5
      drive(32'h00700293, 32'h100);
      #1;
      check("addi_ready", {63'd0, a_in_ready}, 64'd1);
      tick();
      check("addi_valid", {63'd0, a_out_valid}, 64'd1);
      check("addi_imm", {32'd0, a_imm}, 64'd7);
      check("addi_rd", {59'd0, a_rd}, 64'd5);
      drive(32'h00528333, 32'h104);
      wait_accept(bub, ok);
      check("add_accepted", {63'd0, ok}, 64'd1);
      check("add_bubbles", 64'(bub), 64'd2);
      check("add_rd", {59'd0, a_rd}, 64'd6);
      check("add_valid", {63'd0, a_out_valid}, 64'd1);
      check("add_stall", {48'd0, a_stall}, 64'd2);

      // backpressure with a dependent add x7,x6,x6 waiting
      drive(32'h006303B3, 32'h108);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_in_ready", {63'd0, a_in_ready}, 64'd0);
         tick();
         check("bp_valid", {63'd0, a_out_valid}, 64'd1);
         check("bp_rd", {59'd0, a_rd}, 64'd6);
         check("bp_pc", {32'd0, a_pc_out}, 64'h104);
         check("bp_stall", {48'd0, a_stall}, 64'd2);
      end
      out_ready = 1'b1;
      wait_accept(bub, ok);
      check("bp_accepted", {63'd0, ok}, 64'd1);
      check("bp_bubbles", 64'(bub), 64'd2);
      check("bp_rd_after", {59'd0, a_rd}, 64'd7);
      check("bp_stall_after", {48'd0, a_stall}, 64'd4);

      // flush during a hazard stall on add x8,x7,x7
      drive(32'h00738433, 32'h10C);
      #1;
      check("fl_hazard", {63'd0, a_in_ready}, 64'd0);
      tick();
      check("fl_bubble_valid", {63'd0, a_out_valid}, 64'd0);
      check("fl_bubble_pc", {32'd0, a_pc_out}, 64'h108);
      flush = 1'b1;
      #1;
      check("fl_in_ready", {63'd0, a_in_ready}, 64'd0);
      tick();
      flush = 1'b0;
      check("fl_valid", {63'd0, a_out_valid}, 64'd0);
      check("fl_pc32", {32'd0, a_pc_out}, 64'd0);
      check("fl_pc64", b_pc_out, 64'd0);
      check("fl_stall", {48'd0, a_stall}, 64'd5);
      #1;
      check("fl_ready_after", {63'd0, a_in_ready}, 64'd1);
      tick();
      check("fl_rd", {59'd0, a_rd}, 64'd8);
      check("fl_stall_after", {48'd0, a_stall}, 64'd5);

      // decode table, history cleared before each vector
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b0;
         flush = 1'b1;
         tick();
         flush = 1'b0;
         drive(vecs[i].instr, 32'h200 + 32'(i * 4));
         #1;
         check($sformatf("v%0d_ready", i), {63'd0, a_in_ready}, 64'd1);
         tick();
         check($sformatf("v%0d_valid", i), {63'd0, a_out_valid}, 64'd1);
         check($sformatf("v%0d_opcode", i), {57'd0, a_opcode}, {57'd0, vecs[i].opc});
         check($sformatf("v%0d_rd", i), {59'd0, a_rd}, {59'd0, vecs[i].rd});
         check($sformatf("v%0d_rs1", i), {59'd0, a_rs1}, {59'd0, vecs[i].rs1});
         check($sformatf("v%0d_rs2", i), {59'd0, a_rs2}, {59'd0, vecs[i].rs2});
         check($sformatf("v%0d_func3", i), {61'd0, a_func3}, {61'd0, vecs[i].f3});
         check($sformatf("v%0d_func7", i), {57'd0, a_func7}, {57'd0, vecs[i].f7});
         check($sformatf("v%0d_imm32", i), {32'd0, a_imm}, {32'd0, vecs[i].imm[31:0]});
         check($sformatf("v%0d_imm64", i), b_imm, vecs[i].imm);
         check($sformatf("v%0d_illegal", i), {63'd0, a_illegal}, {63'd0, vecs[i].ill});
         check($sformatf("v%0d_illegal64", i), {63'd0, b_illegal}, {63'd0, vecs[i].ill});
         check($sformatf("v%0d_pc", i), {32'd0, a_pc_out}, {32'd0, 32'h200 + 32'(i * 4)});
         check($sformatf("v%0d_pc64", i), b_pc_out, {32'd0, 32'h200 + 32'(i * 4)});
      end

      // illegal op with rd field 5 must not block a reader of x5
      drive(32'h000002FF, 32'h300);
      tick();
      check("ill_flag", {63'd0, a_illegal}, 64'd1);
      check("ill_imm", b_imm, 64'd0);
      drive(32'h00528333, 32'h304);
      #1;
      check("ill_no_hazard", {63'd0, a_in_ready}, 64'd1);
      tick();
      check("ill_next_rd", {59'd0, a_rd}, 64'd6);
      check("ill_next_flag", {63'd0, a_illegal}, 64'd0);

      // store's rd field never enters the history
      drive(32'hFE112E23, 32'h308);
      tick();
      drive(32'h000E0533, 32'h30C);
      #1;
      check("sw_no_hazard", {63'd0, a_in_ready}, 64'd1);
      tick();
      check("sw_next_rd", {59'd0, a_rd}, 64'd10);
      check("final_stall32", {48'd0, a_stall}, 64'd5);
      check("final_stall64", {48'd0, b_stall}, 64'd5);
      in_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised RV32I/RV64I instruction-decode pipeline stage. It sits between fetch and execute and registers the decoded fields together with a sign-extended immediate. Compared with the earlier decode stage it adds a valid/ready handshake, a `HIST_DEPTH`-deep destination-register history for RAW hazard stalls, bubble insertion, flush, and a stall counter.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64; sets the widths of `imm`, `pc_in` and `pc_out`.
- `HIST_DEPTH`, 2, number of previously issued destinations checked for hazards; range 1..4.
- `RESET_PC`, 32'h00400000 (zero-extended to `XLEN`), `pc_out` value after reset.
- `CNT_W`, 16, width of the stall counter.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous squash, e.g. on a taken branch.
- `in_valid`  in  1  `instr_in` and `pc_in` are valid.
- `in_ready`  out  1  the stage accepts the input this cycle (combinational).
- `instr_in`  in  32  instruction word.
- `pc_in`  in  XLEN  PC of `instr_in`.
- `out_valid`  out  1  registered outputs hold a real instruction.
- `out_ready`  in  1  the execute stage consumes the outputs.
- `rs1`, `rs2`, `rd`  out  5 each  register fields.
- `opcode`  out  7
- `func3`  out  3
- `func7`  out  7
- `imm`  out  XLEN  sign-extended immediate.
- `pc_out`  out  XLEN
- `illegal`  out  1  the opcode is not in the supported set.
- `stall_count`  out  CNT_W  number of hazard bubbles inserted.

## Operation
Instruction classes, with what each reads, whether it writes `rd`, and its immediate:
- R, opcode 0110011: reads rs1 and rs2; writes rd; `imm` = 0.
- I, opcodes 0010011, 0000011 and 1100111 (JALR): reads rs1; writes rd; `imm` = sext(instr[31:20]).
- S, opcode 0100011: reads rs1 and rs2; no write; `imm` = sext({instr[31:25], instr[11:7]}).
- B, opcode 1100011: reads rs1 and rs2; no write; `imm` = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U, opcodes 0110111 and 0010111: no reads; writes rd; `imm` = sext({instr[31:12], 12'b0}).
- J, opcode 1101111: no reads; writes rd; `imm` = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Any other opcode: `illegal` = 1; no reads; no write; `imm` = 0.
- `sext` replicates the top bit up to `XLEN`.

Field rules:
- `rs1`, `rs2`, `rd`, `func3` and `func7` are always the raw instruction bit slices, whatever the class.

History and hazard detection:
- The history is `hist[0..HIST_DEPTH-1]`, each entry 5 bits; `hist[0]` is the newest.
- The effective destination is `rd` if the instruction writes and `rd` != 0, otherwise 0.
- `hazard` = `in_valid` AND (a used rs1 != 0 matches any `hist[i]`, OR a used rs2 != 0 matches any `hist[i]`). Only register fields the class actually reads count as used.

Per-cycle behaviour (`adv` = !`out_valid` | `out_ready`):
- `reset`: all outputs are 0, except `pc_out` = `RESET_PC`. The history and `stall_count` are cleared.
- `flush` (when not in reset), which has priority over everything else:
  - `out_valid` = 0 and all fields are zeroed, `pc_out` included.
  - The history is cleared.
  - `in_ready` = 0.
- `adv` & `in_valid` & !`hazard`: the decoded fields load, `out_valid` = 1, and the history shifts with the effective destination entering at `hist[0]`.
- `adv` & `hazard`, i.e. a bubble:
  - `out_valid` = 0 and all fields are zeroed except `pc_out`, which holds.
  - The history shifts with 0 entering at `hist[0]`.
  - `stall_count` increments and saturates at all-ones.
- `adv` & !`in_valid`: a bubble as above, but `stall_count` does not change.
- !`adv`: all registers hold and the history holds.

Ready rule:
- `in_ready` = `adv` & !`hazard` & !`flush` & !`reset`.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle when there are no hazards and `out_ready` = 1.
- A RAW dependency on the instruction issued k cycles earlier (k ≤ `HIST_DEPTH`) costs `HIST_DEPTH` − k + 1 bubbles. Back-to-back dependent instructions therefore cost `HIST_DEPTH` bubbles.
- Downstream backpressure (`out_ready` = 0) freezes the history, so the count of bubbles per hazard is unchanged.
- `rs` = 0 never causes a hazard, and an instruction that does not write (`rd` = 0 or no write class) never enters the history as nonzero.
- `stall_count` is not cleared by `flush`.

## Test plan
- Reset → `out_valid` = 0, `pc_out` = 0x00400000, `stall_count` = 0, `in_ready` = 1 once reset is released.
- Stream 0x00700293 (addi x5,x0,7), then 0x00528333 (add x6,x5,x5), with `out_ready` = 1 and `HIST_DEPTH` = 2 → the addi outputs `imm` = 7 and `rd` = 5. Then come 2 bubble cycles with `in_ready` = 0, the add issues on the 3rd cycle after the addi, and `stall_count` = 2.
- Decode 0xFE112E23 (sw x1,-4(x2)) → `imm` = 0xFFFFFFFC, `rs1` = 2, `rs2` = 1, and the history entry is 0. Decode 0xFF9FF0EF (jal x1,-8) → `imm` = 0xFFFFFFF8 and `rd` = 1. Repeat both with `XLEN` = 64 → `imm` = 0xFFFFFFFFFFFFFFFC and 0xFFFFFFFFFFFFFFF8.
- Hold `out_ready` = 0 for 3 cycles while a dependent instruction waits → all outputs stay stable, the history is frozen, and the bubble count is still 2 after release.
- Assert `flush` during a hazard stall → the next cycle has `out_valid` = 0 and `pc_out` = 0. The history is clear, so the dependent instruction is accepted immediately, and `stall_count` is retained.
- Apply opcode 0x7F → `illegal` = 1, `imm` = 0, and no hazard against a following instruction that reads the same `rd`.
